door_sequencer: RTL and testbench



---
 rtl/door_sequencer.sv | 173 +++++++++++++++++
 tb/tb_door_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/door_sequencer.sv
// Main-door servo sequencer: debounced presence sensing plus an open/hold/close ramp on the servo pulse width.
// Define DOOR_SEQ_OPEN_COUNT_EN to add the saturating open_count output.
module door_sequencer #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOLD_CYC     = 250000000,
  parameter int unsigned STEP_CYC     = 1000000,
  parameter int unsigned POS_CLOSED   = 50000,
  parameter int unsigned POS_OPEN     = 100000,
  parameter int unsigned POS_STEP     = 2500,
  parameter int unsigned PW_W         = 17
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            presence_1,
  input  logic            presence_2,
  input  logic            force_close,
  output logic [PW_W-1:0] pulse_width,
  output logic [1:0]      door_state,
  output logic            busy
`ifdef DOOR_SEQ_OPEN_COUNT_EN
  ,
  output logic [15:0]     open_count
`endif
);

  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int PWX    = PW_W + 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
  localparam logic [PW_W-1:0]   PW_OPEN   = PW_W'(POS_OPEN);
  localparam logic [PW_W-1:0]   PW_CLOSED = PW_W'(POS_CLOSED);
  localparam logic [PW_W-1:0]   PW_STEP   = PW_W'(POS_STEP);
  localparam logic [PW_W:0]     OPEN_X    = PWX'(POS_OPEN);
  localparam logic [PW_W:0]     STEP_X    = PWX'(POS_STEP);
  localparam logic [PW_W:0]     LOW_X     = PWX'(POS_CLOSED) + PWX'(POS_STEP);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    OPENING = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } doorState_e;

  logic [1:0]             sync1_q, sync2_q, deb_q;
  logic [1:0][DEB_W-1:0]  debCnt_q;
  doorState_e             state_q, state_d;
  logic [PW_W-1:0]        pw_q, pw_d;
  logic [STEP_W-1:0]      stepCnt_q, stepCnt_d;
  logic [HOLD_W-1:0]      holdCnt_q, holdCnt_d;
  logic                   busy_q;
  logic                   pres, stepTerm;
  logic [PW_W:0]          pwUp;
  logic [PW_W-1:0]        pwUpSat, pwDnSat;

  // A sensor change is accepted only after it has been stable for DEBOUNCE_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      debCnt_q <= '0;
    end else begin
      sync1_q <= {presence_2, presence_1};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          debCnt_q[i] <= '0;
        end else if (debCnt_q[i] == DEB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          debCnt_q[i] <= '0;
        end else begin
          debCnt_q[i] <= debCnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  assign pres     = deb_q[0] | deb_q[1];
  assign stepTerm = (stepCnt_q == STEP_LAST);
  assign pwUp     = {1'b0, pw_q} + STEP_X;
  assign pwUpSat  = (pwUp >= OPEN_X) ? PW_OPEN : pwUp[PW_W-1:0];
  assign pwDnSat  = ({1'b0, pw_q} <= LOW_X) ? PW_CLOSED : (pw_q - PW_STEP);

  always_comb begin
    state_d   = state_q;
    pw_d      = pw_q;
    stepCnt_d = stepCnt_q;
    holdCnt_d = holdCnt_q;
    unique case (state_q)
      CLOSED: begin
        if (pres && !force_close) begin
          state_d   = OPENING;
          stepCnt_d = '0;
        end
      end
      OPENING: begin
        stepCnt_d = stepTerm ? '0 : stepCnt_q + STEP_W'(1);
        if (stepTerm) pw_d = pwUpSat;
        if (force_close) begin
          state_d   = CLOSING;
          stepCnt_d = '0;
        end else if (stepTerm && (pwUpSat == PW_OPEN)) begin
          state_d   = OPEN;
          holdCnt_d = '0;
        end
      end
      OPEN: begin
        if (force_close) begin
          state_d   = CLOSING;
          stepCnt_d = '0;
        end else if (pres) begin
          holdCnt_d = '0;
        end else if (holdCnt_q == HOLD_LAST) begin
          state_d   = CLOSING;
          stepCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
      end
      CLOSING: begin
        stepCnt_d = stepTerm ? '0 : stepCnt_q + STEP_W'(1);
        if (stepTerm) pw_d = pwDnSat;
        // A reversal beats a final step landing on the same edge; the stepped value is kept.
        if (pres && !force_close) begin
          state_d   = OPENING;
          stepCnt_d = '0;
        end else if (stepTerm && (pwDnSat == PW_CLOSED)) begin
          state_d = CLOSED;
        end
      end
      default: state_d = CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLOSED;
      pw_q      <= PW_CLOSED;
      stepCnt_q <= '0;
      holdCnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pw_q      <= pw_d;
      stepCnt_q <= stepCnt_d;
      holdCnt_q <= holdCnt_d;
      busy_q    <= (state_d == OPENING) || (state_d == CLOSING);
    end
  end

`ifdef DOOR_SEQ_OPEN_COUNT_EN
  logic [15:0] openCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      openCnt_q <= '0;
    end else if ((state_d == OPEN) && (state_q != OPEN) && (openCnt_q != 16'hFFFF)) begin
      openCnt_q <= openCnt_q + 16'd1;
    end
  end

  assign open_count = openCnt_q;
`endif

  assign pulse_width = pw_q;
  assign door_state  = state_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer using small timing parameters so every ramp edge can be counted by hand.
// Edge offsets below are counted from the slot (#1 after a rising edge) where the raw sensor changes.
module tb_door_sequencer;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int STEP = 5;
  localparam int PCL  = 10;
  localparam int POP  = 30;
  localparam int PST  = 6;
  localparam int PW_W = 17;

  logic            clk = 1'b0;
  logic            rst, presence_1, presence_2, force_close;
  logic [PW_W-1:0] pulse_width;
  logic [1:0]      door_state;
  logic            busy;
`ifdef DOOR_SEQ_OPEN_COUNT_EN
  logic [15:0]     open_count;
`endif

  int checks = 0;
  int errors = 0;

  door_sequencer #(
    .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .STEP_CYC(STEP),
    .POS_CLOSED(PCL), .POS_OPEN(POP), .POS_STEP(PST), .PW_W(PW_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .presence_1(presence_1),
    .presence_2(presence_2),
    .force_close(force_close),
    .pulse_width(pulse_width),
    .door_state(door_state),
    .busy(busy)
`ifdef DOOR_SEQ_OPEN_COUNT_EN
    ,
    .open_count(open_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic p1, input logic p2, input logic fc);
    rst         = r;
    presence_1  = p1;
    presence_2  = p2;
    force_close = fc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("reset_pw", 32'(pulse_width), PCL);
    checkOutput("reset_state", 32'(door_state), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // three-cycle glitch on presence_1 must be rejected
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(10);
    checkOutput("glitch_state", 32'(door_state), 0);
    checkOutput("glitch_pw", 32'(pulse_width), PCL);

    // first open: OPENING exactly 7 edges after the raw rise
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(6);
    checkOutput("open_latency_early", 32'(door_state), 0);
    tick(1);
    checkOutput("open_latency", 32'(door_state), 1);
    checkOutput("opening_busy", 32'(busy), 1);
    tick(4);
    checkOutput("ramp_before_step", 32'(pulse_width), PCL);
    tick(1);
    checkOutput("ramp_up_1", 32'(pulse_width), 16);
    tick(5);
    checkOutput("ramp_up_2", 32'(pulse_width), 22);
    tick(5);
    checkOutput("ramp_up_3", 32'(pulse_width), 28);
    tick(5);
    checkOutput("ramp_up_sat", 32'(pulse_width), POP);
    checkOutput("open_state", 32'(door_state), 2);
    checkOutput("open_busy", 32'(busy), 0);
`ifdef DOOR_SEQ_OPEN_COUNT_EN
    checkOutput("open_count_1", 32'(open_count), 1);
`endif

    // presence drops: debounce (6 edges) plus 20 hold edges before CLOSING
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(25);
    checkOutput("hold_still_open", 32'(door_state), 2);
    tick(1);
    checkOutput("hold_expired", 32'(door_state), 3);
    checkOutput("closing_busy", 32'(busy), 1);
    tick(5);
    checkOutput("ramp_dn_1", 32'(pulse_width), 24);
    tick(5);
    checkOutput("ramp_dn_2", 32'(pulse_width), 18);
    tick(5);
    checkOutput("ramp_dn_3", 32'(pulse_width), 12);
    tick(5);
    checkOutput("ramp_dn_sat", 32'(pulse_width), PCL);
    checkOutput("closed_state", 32'(door_state), 0);
    checkOutput("closed_busy", 32'(busy), 0);

    // second open, then a presence_2 reversal while closing
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(7);
    checkOutput("reopen_state", 32'(door_state), 1);
    tick(20);
    checkOutput("reopen_open", 32'(door_state), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(26);
    checkOutput("reclose_state", 32'(door_state), 3);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    checkOutput("rev_pw_24", 32'(pulse_width), 24);
    tick(3);
    checkOutput("rev_not_yet", 32'(door_state), 3);
    tick(1);
    checkOutput("rev_state", 32'(door_state), 1);
    checkOutput("rev_pw_kept", 32'(pulse_width), 24);
    tick(5);
    checkOutput("rev_pw_open", 32'(pulse_width), POP);
    checkOutput("rev_open_state", 32'(door_state), 2);
`ifdef DOOR_SEQ_OPEN_COUNT_EN
    checkOutput("open_count_2", 32'(open_count), 2);
`endif

    // force_close with presence_2 still held: close fully, never reopen
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    checkOutput("fc_closing", 32'(door_state), 3);
    checkOutput("fc_busy", 32'(busy), 1);
    tick(19);
    checkOutput("fc_no_reopen", 32'(door_state), 3);
    checkOutput("fc_pw_12", 32'(pulse_width), 12);
    tick(1);
    checkOutput("fc_closed", 32'(door_state), 0);
    checkOutput("fc_pw_closed", 32'(pulse_width), PCL);
    tick(2);
    checkOutput("fc_stays_closed", 32'(door_state), 0);

    // release force_close, then reset in the middle of OPENING
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("fc_release_open", 32'(door_state), 1);
    tick(5);
    checkOutput("mid_ramp_pw", 32'(pulse_width), 16);
    tick(2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    checkOutput("rst_mid_pw", 32'(pulse_width), PCL);
    checkOutput("rst_mid_state", 32'(door_state), 0);
    checkOutput("rst_mid_busy", 32'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
